// File: rtl/uart_ack_framer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_ack_framer_pkg
// Description : Shared definitions for the UART acknowledgement framer:
//               frame header, frame length, FSM states, queued-event layout.
//               Optional feature macro: ACK_CHECKSUM_EN (adds CHK byte).
// Revision    : 1.0 - initial release
// ============================================================================
package uart_ack_framer_pkg;

    localparam logic [7:0] ACK_HEADER = 8'hA5;

`ifdef ACK_CHECKSUM_EN
    localparam int unsigned ACK_FRAME_BYTES = 4;
`else
    localparam int unsigned ACK_FRAME_BYTES = 3;
`endif

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_START = 3'd2,
        ST_DATA  = 3'd3,
        ST_STOP  = 3'd4,
        ST_NEXT  = 3'd5
    } ack_state_e;

    typedef struct packed {
        logic [3:0] ctrl;
        logic [3:0] value;
        logic [7:0] status;
    } ack_event_t;

`ifdef ACK_CHECKSUM_EN
    // XOR of every byte that precedes the checksum slot
    function automatic logic [7:0] ack_checksum(input ack_event_t ev);
        return ACK_HEADER ^ {ev.ctrl, ev.value} ^ ev.status;
    endfunction
`endif

endpackage
`default_nettype wire

// File: rtl/uart_ack_framer_fifo.sv
`default_nettype none
// ============================================================================
// Module      : ack_fifo
// Description : Synchronous FIFO with full/empty flags. A push while full is
//               accepted only when a pop happens in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module ack_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);

    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam logic [ADDR_W:0] PTR_ONE = (ADDR_W + 1)'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [ADDR_W:0]  wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]  rd_ptr_q, rd_ptr_d;
    logic             w_do_push;
    logic             w_do_pop;

    // Extra pointer MSB distinguishes full from empty when the indices match
    assign o_empty   = (wr_ptr_q == rd_ptr_q);
    assign o_full    = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                       (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_rdata   = mem_q[rd_ptr_q[ADDR_W-1:0]];

    // Pointer advance
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (w_do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (w_do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    end

    // Pointer registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage array; contents need no reset since the pointers gate reads
    always_ff @(posedge clk) begin
        if (w_do_push) mem_q[wr_ptr_q[ADDR_W-1:0]] <= i_wdata;
    end

endmodule
`default_nettype wire

// File: rtl/uart_ack_framer.sv
`default_nettype none
// ============================================================================
// Module      : uart_ack_framer
// Description : Queues command acknowledgement events and sends each as a
//               byte frame (A5, CMD, STATUS[, CHK]) on an 8N1 UART TX line.
//               Optional feature macro: ACK_CHECKSUM_EN (4-byte frame).
// Revision    : 1.0 - initial release
// ============================================================================
module uart_ack_framer
    import uart_ack_framer_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 50_000_000,
    parameter int unsigned BAUD_RATE  = 115200,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ack_valid,
    input  logic [3:0] ack_ctrl,
    input  logic [3:0] ack_value,
    input  logic [7:0] ack_status,
    output logic       uart_tx,
    output logic       busy,
    output logic [7:0] overflow_cnt
);

    localparam int unsigned BAUD_DIV = CLK_FREQ / BAUD_RATE;
    localparam int unsigned CNT_W    = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [1:0] LAST_BYTE = 2'(ACK_FRAME_BYTES - 1);

    ack_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [1:0]       byte_idx_q, byte_idx_d;
    ack_event_t       frame_q, frame_d;
    logic             tx_q, tx_d;
    logic             busy_q, busy_d;
    logic [7:0]       ovf_q, ovf_d;

    ack_event_t       w_wr_ev;
    ack_event_t       w_rd_ev;
    logic             w_fifo_full;
    logic             w_fifo_empty;
    logic             w_push;
    logic             w_pop;
    logic             w_tick;
    logic [7:0]       w_cur_byte;

    assign w_wr_ev = {ack_ctrl, ack_value, ack_status};
    assign w_pop   = (state_q == ST_LOAD);
    // A full FIFO still takes the event if the engine pops in the same cycle
    assign w_push  = ack_valid && !rst && (!w_fifo_full || w_pop);
    assign w_tick  = (cnt_q == CNT_LAST);

    ack_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (16)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_wdata (w_wr_ev),
        .i_pop   (w_pop),
        .o_rdata (w_rd_ev),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    // Byte mux: select the frame byte addressed by the byte index
    always_comb begin
        w_cur_byte = ACK_HEADER;
        case (byte_idx_q)
            2'd1:    w_cur_byte = {frame_q.ctrl, frame_q.value};
            2'd2:    w_cur_byte = frame_q.status;
`ifdef ACK_CHECKSUM_EN
            2'd3:    w_cur_byte = ack_checksum(frame_q);
`endif
            default: w_cur_byte = ACK_HEADER;
        endcase
    end

    // Next-state, bit timer and frame bookkeeping
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + CNT_ONE;
        bit_idx_d  = bit_idx_q;
        byte_idx_d = byte_idx_q;
        frame_d    = frame_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (!w_fifo_empty) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                cnt_d      = '0;
                frame_d    = w_rd_ev;
                byte_idx_d = 2'd0;
                bit_idx_d  = 3'd0;
                state_d    = ST_START;
            end
            ST_START: begin
                if (w_tick) begin
                    cnt_d     = '0;
                    bit_idx_d = 3'd0;
                    state_d   = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_tick) begin
                    cnt_d = '0;
                    if (bit_idx_q == 3'd7) state_d = ST_STOP;
                    else                   bit_idx_d = bit_idx_q + 3'd1;
                end
            end
            ST_STOP: begin
                if (w_tick) begin
                    cnt_d   = '0;
                    state_d = ST_NEXT;
                end
            end
            ST_NEXT: begin
                cnt_d = '0;
                if (byte_idx_q != LAST_BYTE) begin
                    byte_idx_d = byte_idx_q + 2'd1;
                    state_d    = ST_START;
                end else if (!w_fifo_empty) begin
                    state_d = ST_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Registered line level, busy flag and saturating drop counter
    always_comb begin
        tx_d = 1'b1;
        if (state_d == ST_START)     tx_d = 1'b0;
        else if (state_d == ST_DATA) tx_d = w_cur_byte[bit_idx_d];
        busy_d = (state_d != ST_IDLE) || !w_fifo_empty;
        ovf_d  = ovf_q;
        if (ack_valid && !w_push && (ovf_q != 8'hFF)) ovf_d = ovf_q + 8'd1;
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            bit_idx_q  <= 3'd0;
            byte_idx_q <= 2'd0;
            frame_q    <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            ovf_q      <= 8'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_idx_q  <= bit_idx_d;
            byte_idx_q <= byte_idx_d;
            frame_q    <= frame_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            ovf_q      <= ovf_d;
        end
    end

    assign uart_tx      = tx_q;
    assign busy         = busy_q;
    assign overflow_cnt = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_ack_framer.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_ack_framer
// Description : Scoreboard bench for uart_ack_framer. A frame-level model
//               predicts accepted events, drops and busy; a UART receiver
//               decodes the line and compares against the expected bytes.
//               Honours ACK_CHECKSUM_EN for the frame length.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_ack_framer;

    localparam int CLK_FREQ  = 1_000_000;
    localparam int BAUD_RATE = 115200;
    localparam int DEPTH     = 4;
    localparam int D         = CLK_FREQ / BAUD_RATE;
`ifdef ACK_CHECKSUM_EN
    localparam int FB = 4;
`else
    localparam int FB = 3;
`endif
    localparam int FRAME_CYC   = FB * (10 * D + 1);
    localparam int DRAIN_BOUND = (DEPTH + 2) * FRAME_CYC + 50;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ack_valid = 1'b0;
    logic [3:0] ack_ctrl = 4'd0;
    logic [3:0] ack_value = 4'd0;
    logic [7:0] ack_status = 8'd0;
    logic       uart_tx;
    logic       busy;
    logic [7:0] overflow_cnt;

    always #5 clk = ~clk;

    uart_ack_framer #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD_RATE  (BAUD_RATE),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ack_valid    (ack_valid),
        .ack_ctrl     (ack_ctrl),
        .ack_value    (ack_value),
        .ack_status   (ack_status),
        .uart_tx      (uart_tx),
        .busy         (busy),
        .overflow_cnt (overflow_cnt)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // ---------------- reference model (frame level) ----------------
    int         cyc     = 0;
    int         occ     = 0;
    int         pop_at  = -1;
    int         free_at = 0;
    int         ovf_m   = 0;
    bit         busy_m  = 1'b0;
    logic [7:0] exp_q[$];

    always @(posedge clk) begin
        int  occ_b;
        bit  pop;
        bit  acc;
        cyc++;
        if (rst) begin
            occ = 0; pop_at = -1; free_at = 0; ovf_m = 0; busy_m = 1'b0;
            exp_q.delete();
        end else begin
            occ_b = occ;
            pop   = (pop_at == cyc);
            acc   = ack_valid && ((occ_b < DEPTH) || pop);
            if (ack_valid && !acc && ovf_m < 255) ovf_m++;
            if (acc) begin
                exp_q.push_back(8'hA5);
                exp_q.push_back({ack_ctrl, ack_value});
                exp_q.push_back(ack_status);
`ifdef ACK_CHECKSUM_EN
                exp_q.push_back(8'hA5 ^ {ack_ctrl, ack_value} ^ ack_status);
`endif
            end
            if (pop) begin
                free_at = cyc + FRAME_CYC;
                pop_at  = -1;
            end else if (pop_at < 0 && cyc >= free_at && occ_b > 0) begin
                pop_at = cyc + 1;
            end
            occ    = occ_b - int'(pop) + int'(acc);
            busy_m = (pop_at > cyc) || (cyc < free_at) || (occ_b > 0);
        end
    end

    // Continuous flag comparison away from the active edge
    always @(negedge clk) begin
        check("overflow_cnt", int'(overflow_cnt), ovf_m);
        check("busy", int'(busy), int'(busy_m));
    end

    // ---------------- UART receiver / scoreboard monitor ----------------
    bit         rx_active = 1'b0;
    int         rx_cnt    = 0;
    logic [7:0] rx_byte   = 8'd0;

    always @(negedge clk) begin
        logic [7:0] e;
        if (rst) begin
            rx_active = 1'b0;
        end else begin
            if (!rx_active && uart_tx === 1'b0) begin
                rx_active = 1'b1;
                rx_cnt    = 0;
                rx_byte   = 8'd0;
            end
            if (rx_active) begin
                if (rx_cnt == D - 1) check("start_bit_low", int'(uart_tx), 0);
                if (rx_cnt == D && exp_q.size() > 0) begin
                    e = exp_q[0];
                    check("start_bit_len", int'(uart_tx), int'(e[0]));
                end
                for (int i = 0; i < 8; i++)
                    if (rx_cnt == (i + 1) * D + D / 2) rx_byte[i] = uart_tx;
                if (rx_cnt == 9 * D + D / 2) begin
                    check("stop_bit", int'(uart_tx), 1);
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_byte: got %02h, expected none", rx_byte);
                    end else begin
                        e = exp_q.pop_front();
                        check("frame_byte", int'(rx_byte), int'(e));
                    end
                    rx_active = 1'b0;
                end else begin
                    rx_cnt++;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    // Drive one event for one cycle; called at posedge+1, returns at posedge+1
    task automatic ev(input logic [3:0] c, input logic [3:0] v, input logic [7:0] s);
        ack_valid  = 1'b1;
        ack_ctrl   = c;
        ack_value  = v;
        ack_status = s;
        @(posedge clk); #1;
        ack_valid  = 1'b0;
    endtask

    task automatic ev_rand();
        ev(4'($urandom), 4'($urandom), 8'($urandom));
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        int k = 0;
        while ((exp_q.size() != 0 || busy_m || rx_active || occ != 0) && k < DRAIN_BOUND) begin
            @(posedge clk);
            k++;
        end
        #1;
        check({name, "_drained"}, int'(k < DRAIN_BOUND), 1);
        check({name, "_idle_line"}, int'(uart_tx), 1);
        check({name, "_busy_low"}, int'(busy), 0);
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int k;
        int ovf_save;

        // Reset state
        wait_cycles(3);
        check("reset_tx", int'(uart_tx), 1);
        check("reset_busy", int'(busy), 0);
        check("reset_ovf", int'(overflow_cnt), 0);
        rst = 1'b0;
        wait_cycles(2);

        // Single event: first-frame latency and busy rise
        ev(4'h3, 4'h5, 8'h00);
        check("busy_at_N", int'(busy), 0);
        wait_cycles(1);
        check("busy_at_N1", int'(busy), 1);
        check("tx_at_N1", int'(uart_tx), 1);
        wait_cycles(1);
        check("tx_fall_N2", int'(uart_tx), 0);
        drain("single");

        // Second pattern
        ev(4'hF, 4'h1, 8'h02);
        drain("pattern2");

        // Six back-to-back events into a depth-4 FIFO: exactly one drop
        for (int i = 0; i < 6; i++) ev(4'(i), 4'(i + 8), 8'(8'h10 + i));
        drain("burst");
        check("burst_ovf", int'(overflow_cnt), 1);

        // Push on the cycle of a pop while full
        for (int i = 0; i < 5; i++) ev_rand();
        k = 0;
        while (!(pop_at == cyc + 1 && occ == DEPTH) && k < 2 * FRAME_CYC) begin
            wait_cycles(1);
            k++;
        end
        check("full_pop_reached", int'(k < 2 * FRAME_CYC), 1);
        ovf_save = int'(overflow_cnt);
        ev(4'hC, 4'hA, 8'h55);
        check("full_pop_ovf_same", int'(overflow_cnt), ovf_save);
        drain("full_pop");

        // Randomised traffic with random gaps
        for (int i = 0; i < 30; i++) begin
            ev_rand();
            wait_cycles($urandom_range(0, 400));
        end
        drain("random");

        // Reset in the DATA phase of the second byte
        ev(4'h7, 4'h2, 8'h81);
        wait_cycles(14 * D + 2);
        rst = 1'b1;
        wait_cycles(1);
        rst = 1'b0;
        check("midreset_tx", int'(uart_tx), 1);
        check("midreset_busy", int'(busy), 0);
        wait_cycles(30 * D);
        check("midreset_quiet", int'(uart_tx), 1);
        ev(4'h9, 4'h4, 8'h3C);
        drain("after_reset");

        // Saturation of the drop counter
        for (int i = 0; i < 300; i++) ev_rand();
        check("sat_ovf", int'(overflow_cnt), 255);
        drain("saturate");
        check("sat_ovf_hold", int'(overflow_cnt), 255);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_ack_framer.md
# uart_ack_framer

Board-to-PC acknowledgement path for the UART command link. Accepts one-cycle command events (control nibble, value nibble, status byte) from the command decoder side, queues them in a small FIFO, wraps each into a fixed byte frame and serialises it onto the UART TX line (8N1, LSB first). It sits alongside the command receiver, so the PC gets one acknowledgement frame per executed command.

## Interface
- `CLK_FREQ`, default 50_000_000: system clock frequency in Hz.
- `BAUD_RATE`, default 115200: line rate in baud.
- `FIFO_DEPTH`, default 4: number of queued events; must be a power of two, minimum 2.
- `clk`, input, 1: system clock; single clock domain.
- `rst`, input, 1: reset, synchronous and active-high.
- `ack_valid`, input, 1: one-cycle event strobe.
- `ack_ctrl`, input, 4: control nibble of the executed command.
- `ack_value`, input, 4: value nibble of the executed command.
- `ack_status`, input, 8: result code; 0x00 means OK.
- `uart_tx`, output, 1: serial line; idles high.
- `busy`, output, 1: high while the FIFO is non-empty or a frame is in flight.
- `overflow_cnt`, output, 8: count of events dropped because the FIFO was full; saturates at 0xFF.

## Operation
- Event capture: on `ack_valid`=1, push {ack_ctrl, ack_value, ack_status} into the FIFO.
  - If the FIFO is full and no pop happens in the same cycle, drop the event and increment `overflow_cnt` (saturating).
  - If a push and a pop happen in the same cycle while full, accept the push.
- Frame format, byte order on the wire:
  - 0xA5 header.
  - CMD = {ctrl, value}.
  - STATUS.
  - CHK = 0xA5 ^ CMD ^ STATUS (see Configuration).
- FSM states:
  - IDLE: FIFO empty, or just after reset.
  - LOAD: pop one entry and latch it into the frame register; byte index = 0.
  - START: drive 0 for one bit period.
  - DATA: drive the 8 bits LSB first, one bit period each.
  - STOP: drive 1 for one bit period.
  - NEXT: if more bytes remain in the frame, increment the byte index and go to START; otherwise go to LOAD if the FIFO is non-empty, else IDLE.
- Bit timer:
  - Divider `BAUD_DIV` = CLK_FREQ/BAUD_RATE (integer, truncated); 434 at the defaults.
  - Counter counts 0..BAUD_DIV-1 and restarts at every state entry.
- Reset values:
  - `uart_tx`=1, `busy`=0, `overflow_cnt`=0.
  - FIFO pointers = 0, FSM = IDLE.
- Reset mid-frame: the line returns high on the cycle after `rst` is sampled. The partial frame and all queued entries are discarded; no resume.
- `ack_*` inputs are ignored while `rst`=1.

## Timing
- Event sampled at rising edge N: FIFO write at edge N.
- From IDLE:
  - LOAD at N+1.
  - START entered at N+2, so `uart_tx` falls at edge N+2.
- Each bit lasts exactly BAUD_DIV cycles; each byte is 10·BAUD_DIV cycles.
- Bytes within a frame are back-to-back: the NEXT state does not add a bit-period gap.
  - NEXT and LOAD each cost one clock cycle, during which the line holds 1.
- A 4-byte frame occupies 40·BAUD_DIV + 4 cycles, ±1 cycle, on the line.
- `busy` is registered and asserts at edge N+1 after the first push from idle. It deasserts one cycle after STOP of the last byte completes with the FIFO empty.

## Configuration
- `ACK_CHECKSUM_EN`
  - Defined: 4-byte frame (header, CMD, STATUS, CHK).
  - Undefined: 3-byte frame (header, CMD, STATUS); the checksum logic and byte slot are not compiled.

## Structure
- Shared package:
  - `ACK_HEADER` = 8'hA5.
  - Frame byte count, derived from `ACK_CHECKSUM_EN`.
  - FSM state enum (IDLE, LOAD, START, DATA, STOP, NEXT).
  - Queued-event struct {ctrl[3:0], value[3:0], status[7:0]}.
- One sub-module: `ack_fifo`, a synchronous FIFO with full/empty flags, parameterised by depth and width 16.
- FSM, byte mux and bit timer stay in the top level.

## Test plan
- Single event ctrl=3, value=5, status=0x00 (checksum on) → line bytes A5, 35, 00, 90; each bit is 434 cycles; `busy` drops after the last stop bit.
- Checksum off, ctrl=0xF, value=0x1, status=0x02 → exactly 3 bytes A5, F1, 02, then idle high.
- 6 events on consecutive cycles with `FIFO_DEPTH`=4 → entry 1 is loaded at N+1, so no drop on event 5. Expect 5 frames sent in order and `overflow_cnt`=1.
- Push on the same cycle as a pop while the FIFO is full → event accepted, `overflow_cnt` unchanged, frame order preserved.
- Assert `rst` for 1 cycle in the DATA state of byte 2 → `uart_tx`=1 next cycle, `busy`=0, no further start bits. A new event after reset produces a clean full frame.
- 300 events while the FIFO is saturated → `overflow_cnt` stops at 0xFF and does not wrap.
